// File: rtl/round_state_ctrl.sv
// Iterative block-cipher round controller: one S-layer/permutation round per cycle, final key whitening, output handshake.
// Optional feature: define ROUND_ABORT_EN to add an abort input that discards the block in flight.
module round_state_ctrl #(
  parameter int unsigned ROUNDS = 25
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef ROUND_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [5:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
  localparam logic [5:0] FINAL_IDX  = 6'(ROUNDS);

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic         abort_hit;

  // Row r occupies bits [127-32r : 96-32r]; rows rotate left by 0, 1, 12, 13.
  function automatic logic [127:0] perm(input logic [127:0] x);
    logic [127:0] y;
    y[127:96] = x[127:96];
    y[95:64]  = {x[94:64], x[95]};
    y[63:32]  = {x[51:32], x[63:52]};
    y[31:0]   = {x[18:0],  x[31:19]};
    return y;
  endfunction

`ifdef ROUND_ABORT_EN
  assign abort_hit = abort && (fsm_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      S_IDLE: begin
        if (din_valid) begin
          state_d = din;
          round_d = '0;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        state_d = perm(sb_out);
        round_d = round_q + 6'd1;
        if (round_q == LAST_ROUND) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        state_d = state_q ^ rk;
        fsm_d   = S_DONE;
      end
      S_DONE: begin
        if (dout_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    // Abort outranks the output handshake and drops the block without producing it.
    if (abort_hit) begin
      fsm_d   = S_IDLE;
      state_d = '0;
      round_d = '0;
    end
  end

  always_comb begin
    din_ready  = (fsm_q == S_IDLE);
    dout_valid = (fsm_q == S_DONE);
    dout       = (fsm_q == S_DONE) ? state_q : '0;
    rk_idx     = '0;
    sb_in      = state_q;
    case (fsm_q)
      S_RUN: begin
        rk_idx = round_q;
        sb_in  = state_q ^ rk;
      end
      S_FINAL: rk_idx = FINAL_IDX;
      default: rk_idx = '0;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and is only seen on a rising edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the 128-bit state register is reset too, so dout and sb_in read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_round_state_ctrl.sv
// Scoreboard bench for round_state_ctrl: a ROUNDS=1 and a ROUNDS=25 instance, each with its own expected-output queue.
module tb_round_state_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] din;

  logic         din_valid_a, din_ready_a, dout_valid_a, dout_ready_a;
  logic [5:0]   rk_idx_a;
  logic [127:0] rk_a, sb_in_a, sb_out_a, dout_a, key0_a, key1_a;

  logic         din_valid_b, din_ready_b, dout_valid_b, dout_ready_b;
  logic [5:0]   rk_idx_b, key_idx_b;
  logic [127:0] rk_b, sb_in_b, sb_out_b, dout_b, key_val_b;

`ifdef ROUND_ABORT_EN
  logic abort_a, abort_b;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] q_a[$];
  logic [127:0] q_b[$];

  localparam logic [127:0] ONES   = {128{1'b1}};
  localparam logic [127:0] EXP_29 = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;

  function automatic logic [3:0] sbox4(input logic [3:0] v);
    case (v)
      4'h0: return 4'h0;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'h6;
      4'h4: return 4'h7;  4'h5: return 4'h4;  4'h6: return 4'h8;  4'h7: return 4'h9;
      4'h8: return 4'hA;  4'h9: return 4'hB;  4'hA: return 4'h1;  4'hB: return 4'hC;
      4'hC: return 4'hD;  4'hD: return 4'hE;  4'hE: return 4'hF;  default: return 4'h5;
    endcase
  endfunction

  function automatic logic [127:0] sbox_layer(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
    return y;
  endfunction

  assign sb_out_a = sbox_layer(sb_in_a);
  assign sb_out_b = sbox_layer(sb_in_b);
  assign rk_a = (rk_idx_a == 6'd0) ? key0_a : (rk_idx_a == 6'd1) ? key1_a : '0;
  assign rk_b = (rk_idx_b == key_idx_b) ? key_val_b : '0;

  round_state_ctrl #(.ROUNDS(1)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ROUND_ABORT_EN
    .abort      (abort_a),
`endif
    .din        (din),
    .din_valid  (din_valid_a),
    .din_ready  (din_ready_a),
    .rk_idx     (rk_idx_a),
    .rk         (rk_a),
    .sb_in      (sb_in_a),
    .sb_out     (sb_out_a),
    .dout       (dout_a),
    .dout_valid (dout_valid_a),
    .dout_ready (dout_ready_a)
  );

  round_state_ctrl #(.ROUNDS(25)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ROUND_ABORT_EN
    .abort      (abort_b),
`endif
    .din        (din),
    .din_valid  (din_valid_b),
    .din_ready  (din_ready_b),
    .rk_idx     (rk_idx_b),
    .rk         (rk_b),
    .sb_in      (sb_in_b),
    .sb_out     (sb_out_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b),
    .dout_ready (dout_ready_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitors: a handshake is seen at the negedge before the edge that completes it.
  logic hs_a, hs_b;
`ifdef ROUND_ABORT_EN
  assign hs_a = dout_valid_a && dout_ready_a && !abort_a;
  assign hs_b = dout_valid_b && dout_ready_b && !abort_b;
`else
  assign hs_a = dout_valid_a && dout_ready_a;
  assign hs_b = dout_valid_b && dout_ready_b;
`endif

  always @(negedge clk) begin
    if (rst_n && hs_a) begin
      if (q_a.size() == 0) fail_now("a unexpected output");
      else check("a dout", dout_a, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && hs_b) begin
      if (q_b.size() == 0) fail_now("b unexpected output");
      else check("b dout", dout_b, q_b.pop_front());
    end
  end

  task automatic send_a(input logic [127:0] d, input logic [127:0] exp,
                        input logic [127:0] k0, input logic [127:0] k1);
    @(posedge clk); #1;
    key0_a = k0; key1_a = k1; din = d; din_valid_a = 1'b1;
    q_a.push_back(exp);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (din_ready_a) break;
    end
    if (!din_ready_a) fail_now("a din_ready wait");
    @(posedge clk); #1;
    din_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [127:0] d, input logic [127:0] exp);
    @(posedge clk); #1;
    din = d; din_valid_b = 1'b1;
    q_b.push_back(exp);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (din_ready_b) break;
    end
    if (!din_ready_b) fail_now("b din_ready wait");
    @(posedge clk); #1;
    din_valid_b = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 200 && q_a.size() != 0; i++) @(negedge clk);
    if (q_a.size() != 0) fail_now("a drain timeout");
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    for (int i = 0; i < 200 && q_b.size() != 0; i++) @(negedge clk);
    if (q_b.size() != 0) fail_now("b drain timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_valid_a();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dout_valid_a) break;
    end
    if (!dout_valid_a) fail_now("a dout_valid wait");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int highs;
    rst_n = 1'b0; din = '0;
    din_valid_a = 1'b0; dout_ready_a = 1'b1; key0_a = '0; key1_a = '0;
    din_valid_b = 1'b0; dout_ready_b = 1'b1; key_idx_b = 6'd25; key_val_b = '0;
`ifdef ROUND_ABORT_EN
    abort_a = 1'b0; abort_b = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("a reset din_ready", 128'(din_ready_a), 128'd1);
    check("a reset dout_valid", 128'(dout_valid_a), 128'd0);
    check("a reset dout", dout_a, '0);
    check("a reset rk_idx", 128'(rk_idx_a), 128'd0);
    check("b reset din_ready", 128'(din_ready_b), 128'd1);
    check("b reset rk_idx", 128'(rk_idx_b), 128'd0);

    // ROUNDS=1, all-ones block, zero keys; latency is ROUNDS+1 edges
    send_a(ONES, EXP_29, '0, '0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dout_valid_a) break;
      @(posedge clk);
      n++;
    end
    check("a latency", 128'(n), 128'd2);
    drain_a();

    // Final whitening key only
    send_a('0, 128'h1, '0, 128'h1);
    drain_a();

    // Single-nibble patterns exercise each row rotation, including wrap-around
    send_a('0, 128'h10000004_20000008_00004100_00008200, {4{32'hA0000005}}, '0);
    drain_a();

    // Round key cancels the block before the S-layer; result is the final key
    send_a(ONES, 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, ONES,
           128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C);
    drain_a();

    // Back-pressure in DONE; a new din_valid meanwhile must be ignored
    dout_ready_a = 1'b0;
    send_a(ONES, EXP_29, '0, '0);
    wait_valid_a();
    din = '0; din_valid_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("a hold dout", dout_a, EXP_29);
      check("a hold dout_valid", 128'(dout_valid_a), 128'd1);
      check("a hold din_ready", 128'(din_ready_a), 128'd0);
      @(negedge clk);
    end
    din_valid_a = 1'b0;
    @(posedge clk); #1 dout_ready_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("a din_ready after handshake", 128'(din_ready_a), 128'd1);
    check("a dout_valid after handshake", 128'(dout_valid_a), 128'd0);
    check("a queue empty after handshake", 128'(q_a.size()), 128'd0);

`ifdef ROUND_ABORT_EN
    // Abort in DONE beats a simultaneous dout_ready
    dout_ready_a = 1'b0;
    send_a(ONES, EXP_29, '0, '0);
    wait_valid_a();
    @(posedge clk); #1 abort_a = 1'b1; dout_ready_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    @(negedge clk);
    check("a abort dout_valid", 128'(dout_valid_a), 128'd0);
    check("a abort din_ready", 128'(din_ready_a), 128'd1);
    check("a abort state", sb_in_a, '0);
    check("a abort no output", 128'(q_a.size()), 128'd1);
    q_a.delete();
`endif

    // ROUNDS=25, zero block and keys: rk_idx walks 0..24 then 25, valid after 26 edges
    key_idx_b = 6'd25; key_val_b = '0;
    send_b('0, '0);
    for (int i = 0; i <= 25; i++) begin
      @(negedge clk);
      check("b rk_idx sequence", 128'(rk_idx_b), 128'(i));
      check("b valid early", 128'(dout_valid_b), 128'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("b valid at 26", 128'(dout_valid_b), 128'd1);
    drain_b();

    // Reset pulse at round 5 drops the block; a fresh block then completes
    send_b(ONES, '0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rk_idx_b == 6'd5) break;
    end
    if (rk_idx_b != 6'd5) fail_now("b wait round 5");
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("b rst din_ready", 128'(din_ready_b), 128'd1);
    check("b rst dout_valid", 128'(dout_valid_b), 128'd0);
    check("b rst dout", dout_b, '0);
    check("b rst rk_idx", 128'(rk_idx_b), 128'd0);
    check("b rst state", sb_in_b, '0);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dout_valid_b) highs++;
    end
    check("b no output after reset", 128'(highs), 128'd0);
    check("b dropped block pending", 128'(q_b.size()), 128'd1);
    q_b.delete();
    key_val_b = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    send_b('0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    drain_b();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
